// File: rtl/data_ram.sv
// Word-organised data memory on the ram_* interface: single-cycle writes,
// fixed-latency reads sequenced by a small FSM with a wait-state counter.
module data_ram #(
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_read_en_i,
  input  logic [31:0] ram_read_addr_i,
  output logic        ram_read_valid_o,
  output logic [31:0] ram_read_data_o,
  output logic        ram_busy_o,
  input  logic        ram_write_en_i,
  input  logic [31:0] ram_write_addr_i,
  input  logic [31:0] ram_write_data_i
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] rd_idx_q, rd_idx_d;
  logic            rd_oor_q, rd_oor_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0]     mem_q [DEPTH];

  logic [IdxW-1:0] wr_idx;
  logic            wr_oor;
  logic [IdxW-1:0] rd_idx_in;
  logic            rd_oor_in;

  // Any address bit above the word index marks the access out of range.
  assign wr_idx    = ram_write_addr_i[IdxW+1:2];
  assign wr_oor    = |ram_write_addr_i[31:IdxW+2];
  assign rd_idx_in = ram_read_addr_i[IdxW+1:2];
  assign rd_oor_in = |ram_read_addr_i[31:IdxW+2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_idx_d = rd_idx_q;
    rd_oor_d = rd_oor_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (ram_read_en_i) begin
          rd_idx_d = rd_idx_in;
          rd_oor_d = rd_oor_in;
          cnt_d    = 4'(READ_LATENCY - 1);
          state_d  = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          // Array read sees the pre-edge contents, so a same-edge write returns old data.
          rdata_d = rd_oor_q ? 32'h0 : mem_q[rd_idx_q];
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      rd_idx_q <= '0;
      rd_oor_q <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_idx_q <= rd_idx_d;
      rd_oor_q <= rd_oor_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage survives reset; writes are dropped only while reset is held.
  always_ff @(posedge clk) begin
    if (!rst && ram_write_en_i && !wr_oor) begin
      mem_q[wr_idx] <= ram_write_data_i;
    end
  end

  assign ram_read_valid_o = (state_q == StResp);
  assign ram_busy_o       = (state_q != StIdle);
  assign ram_read_data_o  = rdata_q;

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram: directed vector table, reset sequences and
// randomized traffic against a cycle-counting reference model.
module tb_data_ram;

  localparam int unsigned Depth = 1024;
  localparam int unsigned L     = 2;
  localparam int unsigned IdxW  = $clog2(Depth);

  logic        clk;
  logic        rst;
  logic        re;
  logic [31:0] ra;
  logic        rv;
  logic [31:0] rd;
  logic        busy;
  logic        we;
  logic [31:0] wa;
  logic [31:0] wd;

  int checks;
  int failures;

  data_ram #(
    .DEPTH       (Depth),
    .READ_LATENCY(L)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ram_read_en_i   (re),
    .ram_read_addr_i (ra),
    .ram_read_valid_o(rv),
    .ram_read_data_o (rd),
    .ram_busy_o      (busy),
    .ram_write_en_i  (we),
    .ram_write_addr_i(wa),
    .ram_write_data_i(wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: storage array plus the number of edges left until the response.
  logic [31:0] ref_mem [Depth];
  int          m_rem;
  logic [31:0] m_addr;
  logic [31:0] m_data;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if ((a >> (IdxW + 2)) != 0) return 32'h0;
    return ref_mem[a[IdxW+1:2]];
  endfunction

  task automatic model_reset();
    m_rem  = -1;
    m_data = 32'h0;
  endtask

  task automatic model_edge();
    if (m_rem < 0) begin
      if (re) begin
        m_rem  = int'(L);
        m_addr = ra;
      end
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) m_data = ref_read(m_addr);
    end else begin
      m_rem = -1;
    end
    if (we && ((wa >> (IdxW + 2)) == 0)) ref_mem[wa[IdxW+1:2]] = wd;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance one edge, sample 1 time unit later.
  task automatic cycle(input logic w_en, input logic [31:0] w_a, input logic [31:0] w_d,
                       input logic r_en, input logic [31:0] r_a);
    we = w_en; wa = w_a; wd = w_d; re = r_en; ra = r_a;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_busy"}, {31'h0, busy}, {31'h0, m_rem >= 0});
    chk({tag, "_valid"}, {31'h0, rv}, {31'h0, m_rem == 0});
    chk({tag, "_data"}, rd, m_data);
  endtask

  typedef struct {
    logic        w_en;
    logic [31:0] w_a;
    logic [31:0] w_d;
    logic        r_en;
    logic [31:0] r_a;
    logic        e_busy;
    logic        e_valid;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic w_en, input logic [31:0] w_a, input logic [31:0] w_d,
                     input logic r_en, input logic [31:0] r_a,
                     input logic e_b, input logic e_v, input logic [31:0] e_d);
    vec_t v;
    v.w_en = w_en; v.w_a = w_a; v.w_d = w_d; v.r_en = r_en; v.r_a = r_a;
    v.e_busy = e_b; v.e_valid = e_v; v.e_data = e_d;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] w0;
    int          rsp_cnt;
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    we = 1'b0; wa = '0; wd = '0; re = 1'b0; ra = '0;
    model_reset();
    for (int i = 0; i < int'(Depth); i++) ref_mem[i] = 32'h0;

    // Asynchronous reset takes effect before any clock edge.
    #1;
    chk("rst_async_busy", {31'h0, busy}, 32'h0);
    chk("rst_async_valid", {31'h0, rv}, 32'h0);
    chk("rst_async_data", rd, 32'h0);
    #6 rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, '0, 1'b0, '0);
      chk_model("idle");
    end

    for (int i = 0; i < int'(Depth); i++) cycle(1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i), 1'b0, '0);
    chk_model("after_init");

    w0 = 32'h1000_0000;
    // Write then read with misaligned address; address change after acceptance ignored.
    add(1, 32'h10, 32'hDEADBEEF, 0, 32'h0,   0, 0, 32'h0);
    add(0, 32'h0,  32'h0,        1, 32'h13,  1, 0, 32'h0);
    add(0, 32'h0,  32'h0,        0, 32'hFFF, 1, 0, 32'h0);
    add(0, 32'h0,  32'h0,        0, 32'h0,   1, 1, 32'hDEADBEEF);
    add(0, 32'h0,  32'h0,        0, 32'h0,   0, 0, 32'hDEADBEEF);
    // Same-edge hazard: write on the WAIT->RESP edge is not seen.
    add(1, 32'h20, 32'h1,        0, 32'h0,   0, 0, 32'hDEADBEEF);
    add(0, 32'h0,  32'h0,        1, 32'h20,  1, 0, 32'hDEADBEEF);
    add(0, 32'h0,  32'h0,        0, 32'h0,   1, 0, 32'hDEADBEEF);
    add(1, 32'h20, 32'h2,        0, 32'h0,   1, 1, 32'h1);
    add(0, 32'h0,  32'h0,        1, 32'h20,  0, 0, 32'h1);
    add(0, 32'h0,  32'h0,        1, 32'h20,  1, 0, 32'h1);
    add(0, 32'h0,  32'h0,        0, 32'h0,   1, 0, 32'h1);
    add(0, 32'h0,  32'h0,        0, 32'h0,   1, 1, 32'h2);
    add(0, 32'h0,  32'h0,        0, 32'h0,   0, 0, 32'h2);
    // Out of range write dropped, read returns 0, word 0 untouched.
    add(1, 32'h1000, 32'h55,     0, 32'h0,   0, 0, 32'h2);
    add(0, 32'h0,  32'h0,        1, 32'h1000, 1, 0, 32'h2);
    add(0, 32'h0,  32'h0,        0, 32'h0,   1, 0, 32'h2);
    add(0, 32'h0,  32'h0,        0, 32'h0,   1, 1, 32'h0);
    add(0, 32'h0,  32'h0,        0, 32'h0,   0, 0, 32'h0);
    add(0, 32'h0,  32'h0,        1, 32'h0,   1, 0, 32'h0);
    add(0, 32'h0,  32'h0,        0, 32'h0,   1, 0, 32'h0);
    add(0, 32'h0,  32'h0,        0, 32'h0,   1, 1, w0);
    add(0, 32'h0,  32'h0,        0, 32'h0,   0, 0, w0);
    // Held request with stepping address: only IDLE-edge addresses are served.
    add(0, 32'h0,  32'h0,        1, 32'h10,  1, 0, w0);
    add(0, 32'h0,  32'h0,        1, 32'h14,  1, 0, w0);
    add(0, 32'h0,  32'h0,        1, 32'h18,  1, 1, 32'hDEADBEEF);
    add(0, 32'h0,  32'h0,        1, 32'h1C,  0, 0, 32'hDEADBEEF);
    add(0, 32'h0,  32'h0,        1, 32'h20,  1, 0, 32'hDEADBEEF);
    add(0, 32'h0,  32'h0,        1, 32'h24,  1, 0, 32'hDEADBEEF);
    add(0, 32'h0,  32'h0,        0, 32'h28,  1, 1, 32'h2);
    add(0, 32'h0,  32'h0,        0, 32'h0,   0, 0, 32'h2);

    foreach (tbl[i]) begin
      cycle(tbl[i].w_en, tbl[i].w_a, tbl[i].w_d, tbl[i].r_en, tbl[i].r_a);
      chk($sformatf("vec%0d_busy", i), {31'h0, busy}, {31'h0, tbl[i].e_busy});
      chk($sformatf("vec%0d_valid", i), {31'h0, rv}, {31'h0, tbl[i].e_valid});
      chk($sformatf("vec%0d_data", i), rd, tbl[i].e_data);
    end

    // Reset while in WAIT aborts the read.
    cycle(1'b0, '0, '0, 1'b1, 32'h10);
    cycle(1'b0, '0, '0, 1'b0, '0);
    chk("pre_rst_busy", {31'h0, busy}, 32'h1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("midrd_rst_busy", {31'h0, busy}, 32'h0);
    chk("midrd_rst_valid", {31'h0, rv}, 32'h0);
    chk("midrd_rst_data", rd, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_held_valid", {31'h0, rv}, 32'h0);
    #3 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, '0, 1'b0, '0);
      chk_model("post_rst");
    end
    cycle(1'b0, '0, '0, 1'b1, 32'h10);
    cycle(1'b0, '0, '0, 1'b0, '0);
    cycle(1'b0, '0, '0, 1'b0, '0);
    chk("post_rst_rd_valid", {31'h0, rv}, 32'h1);
    chk("post_rst_rd_data", rd, 32'hDEADBEEF);
    cycle(1'b0, '0, '0, 1'b0, '0);

    // Randomized traffic against the model.
    rsp_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      logic        r_w, r_r;
      logic [31:0] r_wa, r_ra;
      r_w  = ($urandom_range(0, 2) == 0);
      r_r  = ($urandom_range(0, 2) != 0);
      r_wa = ($urandom_range(0, 7) == 0) ? $urandom() : ($urandom() & 32'h0000_00FF);
      r_ra = ($urandom_range(0, 7) == 0) ? $urandom() : ($urandom() & 32'h0000_00FF);
      cycle(r_w, r_wa, $urandom(), r_r, r_ra);
      chk_model("rand");
      if (rv) rsp_cnt++;
    end
    chk("rand_saw_responses", {31'h0, rsp_cnt > 20}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
